// File: rtl/mining_pkg.sv
// Shared constants and FSM encoding for the message loader and its slot counter.
// Defining LOADER_PAD_EN adds the ST_PAD state used for SHA-256 padding.
package mining_pkg;

  localparam logic [2:0]  FSM_LOAD       = 3'h1;
  localparam logic [8:0]  SLOT_MSB_FIRST = 9'd511;
  localparam logic [8:0]  SLOT_STEP      = 9'd32;
  localparam logic [3:0]  SLOT_LAST      = 4'd15;
  localparam logic [3:0]  SLOT_LEN_HI    = 4'd14;
  localparam logic [31:0] PAD_MARKER     = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
`ifdef LOADER_PAD_EN
    ,
    ST_PAD  = 2'd3
`endif
  } loader_state_e;

  // Out-of-range lengths are clamped rather than rejected.
  function automatic logic [15:0] clamp_len(input logic [15:0] len, input int max_words);
    if (len == 16'd0) return 16'd1;
    if (int'(len) > max_words) return 16'(max_words);
    return len;
  endfunction

endpackage

// File: rtl/message_loader_slot_counter.sv
// Slot position tracker: slot index 0..15 inside a 512-bit block, the MSB bit
// position of that slot, and the block address that advances on wrap.
module slot_counter
  import mining_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
`ifdef LOADER_PAD_EN
  output logic              at_len_slot,
`endif
  output logic [8:0]        width,
  output logic [ADDR_W-1:0] addr
);

  logic [3:0] slot;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot  <= '0;
      width <= SLOT_MSB_FIRST;
      addr  <= '0;
    end else if (clear) begin
      slot  <= '0;
      width <= SLOT_MSB_FIRST;
      addr  <= '0;
    end else if (advance) begin
      if (slot == SLOT_LAST) begin
        slot  <= '0;
        width <= SLOT_MSB_FIRST;
        addr  <= addr + ADDR_W'(1);
      end else begin
        slot  <= slot + 4'd1;
        width <= width - SLOT_STEP;
      end
    end
  end

`ifdef LOADER_PAD_EN
  assign at_len_slot = (slot == SLOT_LEN_HI);
`endif

endmodule

// File: rtl/message_loader.sv
// Streams message words into 512-bit block slots for the mining core.
// With LOADER_PAD_EN defined, SHA-256 padding and the bit length are appended.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready are
// both high; in_ready is combinational from state and fsm_state, and in_data
// must be held while in_valid is high and in_ready is low.
module message_loader
  import mining_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       msg_len,
  input  logic [2:0]        fsm_state,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic [31:0]       message,
  output logic              msg_we,
  output logic [ADDR_W-1:0] indirizzo,
  output logic [8:0]        indirizzo_width,
  output logic              stopw,
  output logic [ADDR_W-1:0] block_count,
  output logic [1:0]        dbg_state
);

  loader_state_e     state, state_next;
  logic [15:0]       len_q, count_q;
  logic              final_q;
  logic              take_start, accept, write, final_write;
  logic [31:0]       word_out;
  logic [8:0]        slot_width;
  logic [ADDR_W-1:0] slot_addr;
`ifdef LOADER_PAD_EN
  logic              at_len_slot, pad_first, hi_done;
  logic [63:0]       bit_len;

  assign bit_len = {43'd0, len_q, 5'd0};
`endif

  assign dbg_state = state;

  slot_counter #(.ADDR_W(ADDR_W)) u_slot (
    .clock      (clock),
    .reset      (reset),
    .clear      (take_start),
    .advance    (write),
`ifdef LOADER_PAD_EN
    .at_len_slot(at_len_slot),
`endif
    .width      (slot_width),
    .addr       (slot_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    accept      = 1'b0;
    write       = 1'b0;
    final_write = 1'b0;
    take_start  = 1'b0;
    word_out    = in_data;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          take_start = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = (fsm_state == FSM_LOAD);
        accept   = in_ready && in_valid;
        write    = accept;
        if (accept && (count_q == len_q - 16'd1)) begin
`ifdef LOADER_PAD_EN
          state_next = ST_PAD;
`else
          final_write = 1'b1;
          state_next  = ST_DONE;
`endif
        end
      end
`ifdef LOADER_PAD_EN
      ST_PAD: begin
        if (fsm_state == FSM_LOAD) begin
          write = 1'b1;
          if (pad_first) begin
            word_out = PAD_MARKER;
          end else if (at_len_slot) begin
            word_out = bit_len[63:32];
          end else if (hi_done) begin
            word_out    = bit_len[31:0];
            final_write = 1'b1;
            state_next  = ST_DONE;
          end else begin
            word_out = 32'd0;
          end
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      message         <= '0;
      msg_we          <= 1'b0;
      indirizzo       <= '0;
      indirizzo_width <= SLOT_MSB_FIRST;
      stopw           <= 1'b0;
      block_count     <= '0;
      len_q           <= 16'd1;
      count_q         <= '0;
      final_q         <= 1'b0;
    end else begin
      msg_we  <= write;
      final_q <= final_write;
      if (write) begin
        message         <= word_out;
        indirizzo       <= slot_addr;
        indirizzo_width <= slot_width;
      end
      if (final_write) block_count <= slot_addr + ADDR_W'(1);
      if (take_start) begin
        len_q   <= clamp_len(msg_len, MAX_WORDS);
        count_q <= '0;
      end else if (accept) begin
        count_q <= count_q + 16'd1;
      end
      // stopw rises one cycle after the final strobe; a new start wins.
      if (take_start)   stopw <= 1'b0;
      else if (final_q) stopw <= 1'b1;
    end
  end

`ifdef LOADER_PAD_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pad_first <= 1'b1;
      hi_done   <= 1'b0;
    end else if (take_start) begin
      pad_first <= 1'b1;
      hi_done   <= 1'b0;
    end else if (state == ST_PAD && write) begin
      pad_first <= 1'b0;
      if (!pad_first && at_len_slot) hi_done <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_message_loader.sv
// Self-checking bench for message_loader: table of load scenarios with random
// data, handshake and fsm_state stalls, plus reset and stall corner sequences.
module tb_message_loader;

  localparam int ADDR_W    = 16;
  localparam int MAX_WORDS = 1024;

  logic              clock = 1'b0;
  logic              reset, start, in_valid, in_ready, msg_we, stopw;
  logic [15:0]       msg_len;
  logic [2:0]        fsm_state;
  logic [31:0]       in_data, message;
  logic [ADDR_W-1:0] indirizzo, block_count;
  logic [8:0]        indirizzo_width;
  logic [1:0]        dbg_state;

  int checks = 0;
  int passes = 0;
  logic [56:0] exp_q[$];
  logic [31:0] cur_words[$];

  typedef struct {
    int len_in;
    int valid_pct;
    int stall_pct;
    int stall_at;
    bit poke;
    int blocks;
  } vec_t;

  vec_t vecs[9];

  message_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .msg_len        (msg_len),
    .fsm_state      (fsm_state),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .message        (message),
    .msg_we         (msg_we),
    .indirizzo      (indirizzo),
    .indirizzo_width(indirizzo_width),
    .stopw          (stopw),
    .block_count    (block_count),
    .dbg_state      (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int eff_len(input int len_in);
    if (len_in == 0) return 1;
    if (len_in > MAX_WORDS) return MAX_WORDS;
    return len_in;
  endfunction

  // Reference: the full word stream, then slot i goes to block i/16, MSB 511-32*(i%16).
  function automatic void build_expected(input int n);
    logic [31:0] vals[$];
    logic [63:0] bits;
    for (int i = 0; i < n; i++) vals.push_back(cur_words[i]);
    bits = 64'(n) * 64'd32;
`ifdef LOADER_PAD_EN
    vals.push_back(32'h8000_0000);
    while (vals.size() % 16 != 14) vals.push_back(32'h0);
    vals.push_back(bits[63:32]);
    vals.push_back(bits[31:0]);
`endif
    for (int i = 0; i < vals.size(); i++)
      exp_q.push_back({16'(i / 16), 9'(511 - 32 * (i % 16)), vals[i]});
  endfunction

  // Scoreboard: every strobe must match the head of the expected stream.
  always @(negedge clock) begin
    if (reset === 1'b0 && msg_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'd1, 64'd0);
      end else begin
        logic [56:0] e;
        e = exp_q.pop_front();
        check("write", {7'd0, indirizzo, indirizzo_width, message}, {7'd0, e});
      end
    end
  end

  task automatic check_reset_values();
    check("rst_message", message, 0);
    check("rst_msg_we", msg_we, 0);
    check("rst_indirizzo", indirizzo, 0);
    check("rst_width", indirizzo_width, 511);
    check("rst_stopw", stopw, 0);
    check("rst_block_count", block_count, 0);
    check("rst_in_ready", in_ready, 0);
  endtask

  task automatic run_load(input int len_in, input int valid_pct, input int stall_pct,
                          input int stall_at, input bit poke, input int exp_blocks);
    int  n, k, cyc;
    bit  stalled;
    n = eff_len(len_in);
    cur_words.delete();
    for (int i = 0; i < n; i++) cur_words.push_back($urandom);
    build_expected(n);
    start = 1'b1; msg_len = 16'(len_in); in_valid = 1'b0; fsm_state = 3'h1;
    @(negedge clock);
    start = 1'b0;
    #1 check("stopw_clear", stopw, 0);
    k = 0; cyc = 0; stalled = 1'b0;
    while (k < n && cyc < 40 * n + 200) begin
      if (k == stall_at && !stalled) begin
        stalled = 1'b1;
        for (int s = 0; s < 3; s++) begin
          fsm_state = 3'h2; in_valid = 1'b1; in_data = cur_words[k];
          #1 check("stall_ready", in_ready, 0);
          if (s > 0) check("stall_we", msg_we, 0);
          @(negedge clock);
        end
      end
      in_valid  = ($urandom_range(0, 99) < valid_pct);
      fsm_state = ($urandom_range(0, 99) < stall_pct) ? 3'h2 : 3'h1;
      start     = poke && (k == 2);
      msg_len   = poke ? 16'd3 : 16'(len_in);
      in_data   = cur_words[k];
      #1 check("in_ready", in_ready, fsm_state == 3'h1);
      if (in_valid && in_ready) k++;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (k < n) check("load_timeout", k, n);
    cyc = 0;
    while (stopw !== 1'b1 && cyc < 300) begin
      fsm_state = ($urandom_range(0, 99) < stall_pct) ? 3'h2 : 3'h1;
      #1 check("tail_ready", in_ready, 0);
      @(negedge clock);
      cyc++;
    end
    fsm_state = 3'h1;
    check("drained", exp_q.size(), 0);
    check("stopw", stopw, 1);
    check("block_count", block_count, exp_blocks);
  endtask

  initial begin
    int k, cyc;
`ifdef LOADER_PAD_EN
    vecs[0] = '{16,   100, 0,  -1, 1'b0, 2};
    vecs[1] = '{17,   100, 0,  -1, 1'b0, 2};
    vecs[2] = '{16,   100, 0,   6, 1'b0, 2};
    vecs[3] = '{1,    70,  10, -1, 1'b0, 1};
    vecs[4] = '{0,    80,  0,  -1, 1'b0, 1};
    vecs[5] = '{14,   60,  20, -1, 1'b1, 2};
    vecs[6] = '{40,   50,  25, -1, 1'b1, 3};
    vecs[7] = '{15,   100, 0,  -1, 1'b0, 2};
    vecs[8] = '{2000, 90,  5,  -1, 1'b0, 65};
`else
    vecs[0] = '{16,   100, 0,  -1, 1'b0, 1};
    vecs[1] = '{17,   100, 0,  -1, 1'b0, 2};
    vecs[2] = '{16,   100, 0,   6, 1'b0, 1};
    vecs[3] = '{1,    70,  10, -1, 1'b0, 1};
    vecs[4] = '{0,    80,  0,  -1, 1'b0, 1};
    vecs[5] = '{14,   60,  20, -1, 1'b1, 1};
    vecs[6] = '{40,   50,  25, -1, 1'b1, 3};
    vecs[7] = '{15,   100, 0,  -1, 1'b0, 1};
    vecs[8] = '{2000, 90,  5,  -1, 1'b0, 64};
`endif
    reset = 1'b1; start = 1'b0; msg_len = 16'd0; fsm_state = 3'h1;
    in_valid = 1'b0; in_data = 32'd0;
    repeat (2) @(negedge clock);
    #1 check_reset_values();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 9; v++)
      run_load(vecs[v].len_in, vecs[v].valid_pct, vecs[v].stall_pct,
               vecs[v].stall_at, vecs[v].poke, vecs[v].blocks);

    // Reset in the middle of a block: nine words in, next slot is 9.
    cur_words.delete();
    for (int i = 0; i < 32; i++) cur_words.push_back($urandom);
    build_expected(32);
    start = 1'b1; msg_len = 16'd32;
    @(negedge clock);
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < 9 && cyc < 100) begin
      in_valid = 1'b1; fsm_state = 3'h1; in_data = cur_words[k];
      #1 if (in_valid && in_ready) k++;
      @(negedge clock);
      cyc++;
    end
    if (k < 9) check("reset_seq_timeout", k, 9);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_values();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      #1 check("post_reset_we", msg_we, 0);
      check("post_reset_ready", in_ready, 0);
    end
    @(negedge clock);
    run_load(1, 100, 0, -1, 1'b0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
